// File: rtl/game_timer_if.sv
// Control/status bundle between the game logic and the countdown timer.
// The timer is the slave: it takes start/pause and reports time and status.
interface game_timer_if;
    logic       start;
    logic       pause;
    logic [7:0] time_bcd;
    logic       sec_tick;
    logic       running;
    logic       time_up;

    modport master (
        output start,
        output pause,
        input  time_bcd,
        input  sec_tick,
        input  running,
        input  time_up
    );

    modport slave (
        input  start,
        input  pause,
        output time_bcd,
        output sec_tick,
        output running,
        output time_up
    );
endinterface

// File: rtl/game_timer.sv
// Game countdown timer: a prescaler divides clk down to game seconds and a
// two-digit BCD counter runs from GAME_SECONDS down to zero.
//
//   state     | meaning
//   ----------+-----------------------------------------------------------
//   ST_IDLE   | after reset, outputs at zero, waiting for start
//   ST_RUN    | counting; running=1
//   ST_PAUSED | prescaler and time frozen; no sec_tick
//   ST_END    | time expired, time_bcd=00, time_up=1 until the next start
//
// Pause simply gates the prescaler: every cycle with pause low in RUN or
// PAUSED is a counted cycle, so pausing neither loses nor adds cycles.
// time_up feeds module_en of the end-screen overlay.
module game_timer #(
    parameter int CLK_FREQ_HZ  = 65_000_000,
    parameter int GAME_SECONDS = 60
) (
    input  logic         clk,
    input  logic         rst,
    game_timer_if.slave  bus
);

    localparam int            PW         = (CLK_FREQ_HZ > 2) ? $clog2(CLK_FREQ_HZ) : 1;
    localparam logic [PW-1:0] PRESC_MAX  = PW'(CLK_FREQ_HZ - 1);
    localparam logic [7:0]    LOAD_BCD   = {4'(GAME_SECONDS / 10), 4'(GAME_SECONDS % 10)};

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_PAUSED = 2'd2,
        ST_END    = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [7:0]    time_q, time_d;
    logic          tick_q, tick_d;
    logic          running_q, running_d;
    logic          time_up_q, time_up_d;

    function automatic logic [7:0] bcd_dec(input logic [7:0] v);
        if (v[3:0] == 4'd0) begin
            return {v[7:4] - 4'd1, 4'd9};
        end
        return {v[7:4], v[3:0] - 4'd1};
    endfunction

    // Next-state, prescaler and BCD countdown; start overrides everything.
    always_comb begin
        state_d = state_q;
        presc_d = presc_q;
        time_d  = time_q;
        tick_d  = 1'b0;
        if (bus.start) begin
            state_d = ST_RUN;
            presc_d = '0;
            time_d  = LOAD_BCD;
        end else begin
            case (state_q)
                ST_RUN, ST_PAUSED: begin
                    if (bus.pause) begin
                        state_d = ST_PAUSED;
                    end else begin
                        state_d = ST_RUN;
                        if (presc_q == PRESC_MAX) begin
                            presc_d = '0;
                            tick_d  = 1'b1;
                            if (time_q == 8'h01) begin
                                time_d  = 8'h00;
                                state_d = ST_END;
                            end else begin
                                time_d = bcd_dec(time_q);
                            end
                        end else begin
                            presc_d = presc_q + 1'b1;
                        end
                    end
                end
                ST_IDLE, ST_END: begin
                    state_d = state_q;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
        running_d = (state_d == ST_RUN);
        time_up_d = (state_d == ST_END);
    end

    // State, counters and registered status outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            presc_q   <= '0;
            time_q    <= 8'h00;
            tick_q    <= 1'b0;
            running_q <= 1'b0;
            time_up_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            presc_q   <= presc_d;
            time_q    <= time_d;
            tick_q    <= tick_d;
            running_q <= running_d;
            time_up_q <= time_up_d;
        end
    end

    assign bus.time_bcd = time_q;
    assign bus.sec_tick = tick_q;
    assign bus.running  = running_q;
    assign bus.time_up  = time_up_q;

endmodule

// File: tb/tb_game_timer.sv
// Bench for game_timer: a 12-second instance and a 1-second instance share
// clk/rst/start/pause and are both compared every cycle against a
// seconds-and-cycles reference model, plus directed timing checks.
module tb_game_timer;
    localparam int F = 4;

    logic clk = 1'b0;
    logic rst;
    logic start;
    logic pause;

    int checks = 0;
    int errors = 0;

    game_timer_if bus_a ();
    game_timer_if bus_b ();

    assign bus_a.start = start;
    assign bus_a.pause = pause;
    assign bus_b.start = start;
    assign bus_b.pause = pause;

    game_timer #(.CLK_FREQ_HZ(F), .GAME_SECONDS(12)) dut_a (.clk(clk), .rst(rst), .bus(bus_a.slave));
    game_timer #(.CLK_FREQ_HZ(F), .GAME_SECONDS(1))  dut_b (.clk(clk), .rst(rst), .bus(bus_b.slave));

    always #5 clk = ~clk;

    // Reference model: remaining whole seconds and counted cycles in the current second.
    int gs [2] = '{12, 1};
    int m_rem [2];
    int m_el [2];
    bit m_live [2];
    bit m_paused [2];
    bit m_done [2];
    bit m_tick [2];

    function automatic logic [7:0] to_bcd(input int n);
        logic [7:0] r;
        r[7:4] = 4'(n / 10);
        r[3:0] = 4'(n % 10);
        return r;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_rem[i] = 0; m_el[i] = 0; m_live[i] = 0;
            m_paused[i] = 0; m_done[i] = 0; m_tick[i] = 0;
        end
    endtask

    task automatic model_edge();
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                m_rem[i] = 0; m_el[i] = 0; m_live[i] = 0;
                m_paused[i] = 0; m_done[i] = 0; m_tick[i] = 0;
            end else if (start) begin
                m_rem[i] = gs[i]; m_el[i] = 0; m_live[i] = 1;
                m_paused[i] = 0; m_done[i] = 0; m_tick[i] = 0;
            end else if (m_live[i] && !m_done[i]) begin
                m_tick[i] = 0;
                if (pause) begin
                    m_paused[i] = 1;
                end else begin
                    m_paused[i] = 0;
                    m_el[i]++;
                    if (m_el[i] == F) begin
                        m_el[i] = 0;
                        m_rem[i]--;
                        m_tick[i] = 1;
                        if (m_rem[i] == 0) m_done[i] = 1;
                    end
                end
            end else begin
                m_tick[i] = 0;
            end
        end
    endtask

    task automatic cmp(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_all();
        logic [7:0] o_t [2];
        logic       o_k [2];
        logic       o_r [2];
        logic       o_u [2];
        o_t[0] = bus_a.time_bcd; o_k[0] = bus_a.sec_tick; o_r[0] = bus_a.running; o_u[0] = bus_a.time_up;
        o_t[1] = bus_b.time_bcd; o_k[1] = bus_b.sec_tick; o_r[1] = bus_b.running; o_u[1] = bus_b.time_up;
        for (int i = 0; i < 2; i++) begin
            cmp($sformatf("time_bcd[%0d]", i), o_t[i], to_bcd(m_rem[i]));
            cmp($sformatf("sec_tick[%0d]", i), {7'd0, o_k[i]}, {7'd0, m_tick[i]});
            cmp($sformatf("running[%0d]", i), {7'd0, o_r[i]}, {7'd0, m_live[i] & ~m_done[i] & ~m_paused[i]});
            cmp($sformatf("time_up[%0d]", i), {7'd0, o_u[i]}, {7'd0, m_done[i]});
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    initial begin
        int n;
        int ticks;
        int last_tick;
        bit found;

        start = 1'b0;
        pause = 1'b0;
        rst   = 1'b0;
        #1 rst = 1'b1;
        #1;
        model_reset();
        check_all();
        step();
        step();
        rst = 1'b0;

        // IDLE ignores pause
        pause = 1'b1;
        repeat (3) step();
        pause = 1'b0;

        // Scenario 1 (+ scenario 6 on instance b): full countdown
        start = 1'b1;
        step();
        start = 1'b0;
        cmp("s1_load", bus_a.time_bcd, 8'h12);
        cmp("s1_running", {7'd0, bus_a.running}, 8'd1);
        ticks = 0;
        last_tick = 0;
        found = 0;
        for (int c = 1; c <= 100 && !found; c++) begin
            step();
            if (bus_b.sec_tick === 1'b1)
                cmp("s6_tick_with_time_up", {7'd0, bus_b.time_up}, 8'd1);
            if (bus_a.sec_tick === 1'b1) begin
                ticks++;
                cmp("s1_tick_interval", 8'(c - last_tick), 8'd4);
                cmp("s1_tick_value", bus_a.time_bcd, to_bcd(12 - ticks));
                last_tick = c;
            end
            if (bus_a.time_up === 1'b1) found = 1;
        end
        cmp("s1_reached_end", {7'd0, found}, 8'd1);
        cmp("s1_tick_count", 8'(ticks), 8'd12);
        cmp("s1_end_running", {7'd0, bus_a.running}, 8'd0);
        cmp("s6_hold_zero", bus_b.time_bcd, 8'h00);
        repeat (3) step();

        // Scenario 3: restart at 05
        start = 1'b1;
        step();
        start = 1'b0;
        found = 0;
        for (int c = 0; c < 100 && !found; c++) begin
            step();
            if (m_rem[0] == 5) found = 1;
        end
        cmp("s3_reached_05", {7'd0, found}, 8'd1);
        cmp("s3_at_05", bus_a.time_bcd, 8'h05);
        start = 1'b1;
        step();
        start = 1'b0;
        cmp("s3_reload", bus_a.time_bcd, 8'h12);
        n = 0;
        found = 0;
        for (int c = 1; c <= 10 && !found; c++) begin
            step();
            if (bus_a.sec_tick === 1'b1) begin found = 1; n = c; end
        end
        cmp("s3_tick_latency", 8'(n), 8'd4);

        // Scenario 2: pause 7 cycles with prescaler at 2
        found = 0;
        for (int c = 0; c < 20 && !found; c++) begin
            step();
            if (m_el[0] == 2 && !m_paused[0]) found = 1;
        end
        cmp("s2_reached_presc2", {7'd0, found}, 8'd1);
        pause = 1'b1;
        repeat (7) begin
            step();
            cmp("s2_no_tick_paused", {7'd0, bus_a.sec_tick}, 8'd0);
        end
        pause = 1'b0;
        n = 0;
        found = 0;
        for (int c = 1; c <= 10 && !found; c++) begin
            step();
            if (bus_a.sec_tick === 1'b1) begin found = 1; n = c; end
        end
        cmp("s2_resume_latency", 8'(n), 8'd2);

        // Scenario 4: start and pause together from IDLE
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();
        start = 1'b1;
        pause = 1'b1;
        step();
        start = 1'b0;
        cmp("s4_run_first", {7'd0, bus_a.running}, 8'd1);
        repeat (5) begin
            step();
            cmp("s4_frozen", bus_a.time_bcd, 8'h12);
        end

        // Scenario 5: async reset between edges while PAUSED
        #3 rst = 1'b1;
        #1;
        model_reset();
        check_all();
        cmp("s5_async_time", bus_a.time_bcd, 8'h00);
        step();
        rst = 1'b0;
        pause = 1'b0;
        repeat (3) step();
        start = 1'b1;
        step();
        start = 1'b0;
        cmp("s5_fresh", bus_a.time_bcd, 8'h12);
        repeat (6) step();

        // Randomized phase
        for (int c = 0; c < 800; c++) begin
            rst   = ($urandom_range(0, 199) == 0);
            start = ($urandom_range(0, 59) == 0);
            pause = ($urandom_range(0, 9) < 2);
            step();
        end
        rst = 1'b0;
        start = 1'b0;
        pause = 1'b0;
        repeat (2) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
